// File: rtl/quad_gen.sv
// Quadrature A/B waveform generator: emits N Gray-code detent cycles per accepted step command.
// Optional position tracking is built only when QGEN_POS_TRACK_EN is defined; otherwise pos is tied to 0.
module quad_gen #(
    parameter int PHASE_CYCLES = 16000,
    parameter int CW           = 5,
    parameter int LIMIT        = 19,
    parameter int WIDTH        = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CW-1:0]    cmd_count,
    input  logic             abort,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] pos,
    output logic [2:0]       dbg_state
);

    localparam int PW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(PHASE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_P1   = 3'd1,
        S_P2   = 3'd2,
        S_P3   = 3'd3,
        S_P4   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic [CW-1:0]   rem_q, rem_d;
    logic            dir_q, dir_d;
    logic            abort_q, abort_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic [1:0]      ab_q, ab_d;
    logic            phase_end;
    logic            accept;

    // Handshake: a command transfers on a clk edge where cmd_valid && cmd_ready;
    // cmd_ready is high only in IDLE, and cmd_valid while not ready is dropped, never queued.
    assign cmd_ready = (state_q == S_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign phase_end = (phase_q == PHASE_LAST);

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        abort_d = abort_q;
        done_d  = 1'b0;
        phase_d = phase_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (cmd_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_P1;
                        rem_d   = cmd_count;
                        dir_d   = cmd_dir;
                    end
                end
            end
            S_P1: if (phase_end) state_d = S_P2;
            S_P2: if (phase_end) state_d = S_P3;
            S_P3: if (phase_end) state_d = S_P4;
            S_P4: begin
                if (phase_end) begin
                    if ((rem_q > CW'(1)) && !abort_q) begin
                        rem_d   = rem_q - 1'b1;
                        state_d = S_P1;
                    end else begin
                        rem_d   = '0;
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort is sticky while busy and only honoured at the end of P4.
        if ((state_q != S_IDLE) && abort) abort_d = 1'b1;
        if (state_d == S_IDLE) abort_d = 1'b0;

        if (state_d != state_q) begin
            phase_d = '0;
        end else if (state_q != S_IDLE) begin
            phase_d = phase_q + 1'b1;
        end
    end

    // Registered outputs are computed from the next state so they line up with state_q.
    always_comb begin
        ab_d   = 2'b11;
        busy_d = (state_d != S_IDLE);
        case (state_d)
            S_P1:    ab_d = dir_d ? 2'b01 : 2'b10;
            S_P2:    ab_d = 2'b00;
            S_P3:    ab_d = dir_d ? 2'b10 : 2'b01;
            default: ab_d = 2'b11;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            abort_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ab_q    <= 2'b11;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            abort_q <= abort_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ab_q    <= ab_d;
        end
    end

    assign a         = ab_q[1];
    assign b         = ab_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;

`ifdef QGEN_POS_TRACK_EN
    logic [WIDTH-1:0] pos_q, pos_d;

    // Mirrors the decoder: the count moves once per detent, at the end of P1.
    always_comb begin
        pos_d = pos_q;
        if ((state_q == S_P1) && phase_end) begin
            if (dir_q) begin
                if (pos_q < WIDTH'(LIMIT)) pos_d = pos_q + 1'b1;
            end else begin
                if (pos_q > WIDTH'(1)) pos_d = pos_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_q <= WIDTH'(9);
        end else begin
            pos_q <= pos_d;
        end
    end

    assign pos = pos_q;
`else
    assign pos = '0;
`endif

endmodule

// File: tb/tb_quad_gen.sv
// Self-checking bench for quad_gen: directed and randomized step commands against a per-cycle waveform model.
module tb_quad_gen;

    localparam int PC    = 4;
    localparam int CW    = 5;
    localparam int LIMIT = 19;
    localparam int WIDTH = 6;
    localparam int W     = 5 + WIDTH;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_dir;
    logic [CW-1:0]    cmd_count;
    logic             abort;
    logic             a;
    logic             b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] pos;
    logic [2:0]       dbg_state;

    int compared   = 0;
    int mismatched = 0;
    int pos_m      = 9;
    logic [W-1:0] exp_q[$];
    logic [1:0]   inc_seq[4];
    logic [1:0]   dec_seq[4];

    quad_gen #(
        .PHASE_CYCLES(PC),
        .CW(CW),
        .LIMIT(LIMIT),
        .WIDTH(WIDTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir),
        .cmd_count(cmd_count),
        .abort(abort),
        .a(a),
        .b(b),
        .busy(busy),
        .done(done),
        .pos(pos),
        .dbg_state(dbg_state)
    );

    // Clock and reset
    always #5 clk = ~clk;

    // Expected vector: {cmd_ready, busy, done, a, b, pos}
    function automatic logic [W-1:0] pack(input logic rdy, input logic bsy, input logic dn,
                                          input logic [1:0] ab, input int p);
        logic [WIDTH-1:0] pv;
`ifdef QGEN_POS_TRACK_EN
        pv = WIDTH'(p);
`else
        pv = '0;
`endif
        return {rdy, bsy, dn, ab, pv};
    endfunction

    task automatic check(input string tag, input logic [W-1:0] exp_v);
        logic [W-1:0] obs;
        obs = {cmd_ready, busy, done, a, b, pos};
        compared++;
        assert (obs === exp_v) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Idle cycles; abort is toggled randomly to confirm it has no effect in IDLE.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            abort = 1'($urandom_range(0, 1));
            tick();
            check($sformatf("idle%0d", i), pack(1'b1, 1'b0, 1'b0, 2'b11, pos_m));
        end
        abort = 1'b0;
    endtask

    // Issue one command and compare every cycle up to and including the done cycle.
    // Returns positioned in the done cycle so a following call exercises back-to-back accept.
    task automatic run_cmd(input logic dir, input int count, input int abort_k, input bit noise);
        int n;
        int len;
        cmd_valid = 1'b1;
        cmd_dir   = dir;
        cmd_count = CW'(count);
        tick();
        cmd_valid = 1'b0;
        cmd_count = CW'($urandom_range(0, 31));
        cmd_dir   = 1'($urandom_range(0, 1));

        n = count;
        if (abort_k >= 0 && (abort_k / (4 * PC) + 1) < count) n = abort_k / (4 * PC) + 1;

        exp_q.delete();
        for (int d = 0; d < n; d++) begin
            for (int p = 0; p < 4; p++) begin
                for (int h = 0; h < PC; h++) begin
                    if (p == 1 && h == 0) begin
                        if (dir) pos_m = (pos_m < LIMIT) ? pos_m + 1 : pos_m;
                        else     pos_m = (pos_m > 1) ? pos_m - 1 : pos_m;
                    end
                    exp_q.push_back(pack(1'b0, 1'b1, 1'b0, dir ? inc_seq[p] : dec_seq[p], pos_m));
                end
            end
        end
        exp_q.push_back(pack(1'b1, 1'b0, 1'b1, 2'b11, pos_m));

        len = exp_q.size();
        for (int k = 0; k < len; k++) begin
            check($sformatf("cmd dir%0d cnt%0d k%0d", dir, count, k), exp_q[k]);
            abort = (k == abort_k);
            if (noise && k < len - 1) begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_dir   = 1'($urandom_range(0, 1));
                cmd_count = CW'($urandom_range(0, 31));
            end else begin
                cmd_valid = 1'b0;
            end
            if (k < len - 1) tick();
        end
        abort     = 1'b0;
        cmd_valid = 1'b0;
    endtask

    initial begin
        int cnt;
        int ak;

        inc_seq[0] = 2'b01; inc_seq[1] = 2'b00; inc_seq[2] = 2'b10; inc_seq[3] = 2'b11;
        dec_seq[0] = 2'b10; dec_seq[1] = 2'b00; dec_seq[2] = 2'b01; dec_seq[3] = 2'b11;

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_dir   = 1'b0;
        cmd_count = '0;
        abort     = 1'b0;
        #2;
        check("reset_async", pack(1'b1, 1'b0, 1'b0, 2'b11, pos_m));
        tick();
        tick();
        check("reset_held", pack(1'b1, 1'b0, 1'b0, 2'b11, pos_m));
        reset = 1'b0;
        idle(2);

        // Single increment detent
        run_cmd(1'b1, 1, -1, 1'b0);
        idle(3);

        // Three decrement detents with ignored command noise while busy
        run_cmd(1'b0, 3, -1, 1'b1);
        idle(2);

        // Zero-count command: done only
        run_cmd(1'b1, 0, -1, 1'b0);
        idle(2);

        // Abort mid-P2 of the second detent
        run_cmd(1'b1, 5, 4 * PC + PC + 1, 1'b0);
        idle(2);

        // Back-to-back commands
        run_cmd(1'b1, 2, -1, 1'b0);
        run_cmd(1'b0, 1, -1, 1'b0);
        run_cmd(1'b1, 0, -1, 1'b0);
        idle(1);

        // Asynchronous reset in the middle of P3
        cmd_valid = 1'b1;
        cmd_dir   = 1'b1;
        cmd_count = CW'(3);
        tick();
        cmd_valid = 1'b0;
        repeat (2 * PC + 1) tick();
        pos_m = (pos_m < LIMIT) ? pos_m + 1 : pos_m;
        check("mid_p3", pack(1'b0, 1'b1, 1'b0, 2'b10, pos_m));
        #3 reset = 1'b1;
        #1;
        pos_m = 9;
        check("reset_mid_p3", pack(1'b1, 1'b0, 1'b0, 2'b11, pos_m));
        @(posedge clk);
        #1 reset = 1'b0;
        idle(1);
        run_cmd(1'b1, 1, -1, 1'b0);
        idle(1);

        // Randomized commands
        for (int it = 0; it < 12; it++) begin
            cnt = $urandom_range(0, 12);
            ak  = -1;
            if (cnt > 0 && $urandom_range(0, 2) == 0)
                ak = $urandom_range(0, cnt - 1) * 4 * PC + $urandom_range(0, 4 * PC - 2);
            run_cmd(1'($urandom_range(0, 1)), cnt, ak, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
        idle(1);

        // Maximum count without wrap, then walk down to the lower bound
        run_cmd(1'b1, 31, -1, 1'b0);
        idle(1);
        run_cmd(1'b0, 25, -1, 1'b0);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
